// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register: opcode encoding and the stored slot layout.
package instr_register_pkg;

  localparam int OP_W  = 32;
  localparam int RES_W = 64;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef struct packed {
    opcode_t                 opcode;
    logic signed [OP_W-1:0]  op_a;
    logic signed [OP_W-1:0]  op_b;
    logic signed [RES_W-1:0] result;
  } instruction_t;

endpackage

// File: rtl/instr_alu.sv
// Combinational signed result generator for a loaded instruction.
module instr_alu
  import instr_register_pkg::*;
#(
  parameter int OP_WIDTH  = OP_W,
  parameter int RES_WIDTH = RES_W
) (
  input  opcode_t                      opcode,
  input  logic signed [OP_WIDTH-1:0]   operand_a,
  input  logic signed [OP_WIDTH-1:0]   operand_b,
  output logic signed [RES_WIDTH-1:0]  result,
  output logic                         div_by_zero
);

  logic signed [RES_WIDTH-1:0] a_x;
  logic signed [RES_WIDTH-1:0] b_x;
  logic                        b_zero;

  assign a_x    = {{(RES_WIDTH-OP_WIDTH){operand_a[OP_WIDTH-1]}}, operand_a};
  assign b_x    = {{(RES_WIDTH-OP_WIDTH){operand_b[OP_WIDTH-1]}}, operand_b};
  assign b_zero = (operand_b == '0);

  // Operands are widened first so MULT keeps the full product and DIV of
  // the most negative value by -1 cannot overflow.
  always_comb begin
    result      = '0;
    div_by_zero = 1'b0;
    unique case (opcode)
      PASSA: result = a_x;
      PASSB: result = b_x;
      ADD:   result = a_x + b_x;
      SUB:   result = a_x - b_x;
      MULT:  result = a_x * b_x;
      DIV: begin
        div_by_zero = b_zero;
        if (!b_zero) result = a_x / b_x;
      end
      MOD: begin
        div_by_zero = b_zero;
        if (!b_zero) result = a_x % b_x;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/instr_register_fifo.sv
// Instruction store with addressed and FIFO access modes; results are computed
// at load time and held alongside the operands.
module instr_register_fifo
  import instr_register_pkg::*;
#(
  parameter int  DEPTH     = 32,
  parameter int  OP_WIDTH  = OP_W,
  parameter int  RES_WIDTH = RES_W,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mode,
  input  logic                       load_en,
  input  opcode_t                    opcode,
  input  logic signed [OP_WIDTH-1:0] operand_a,
  input  logic signed [OP_WIDTH-1:0] operand_b,
  input  logic [AW-1:0]              write_pointer,
  input  logic                       read_en,
  input  logic [AW-1:0]              read_pointer,
  output instruction_t               instruction_word,
  output logic                       valid_out,
  output logic                       full,
  output logic                       empty,
  output logic [AW:0]                count,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       div_by_zero
);

  instruction_t mem_q [DEPTH];

  logic               mode_q;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  instruction_t       word_q, word_d;
  logic               valid_q, valid_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               dbz_q, dbz_d;

  logic                        mode_chg;
  logic                        full_w, empty_w;
  logic                        wr_en, rd_en;
  logic [AW-1:0]               wr_idx, rd_idx;
  logic signed [RES_WIDTH-1:0] alu_res;
  logic                        alu_dbz;
  instruction_t                wr_entry;

  instr_alu #(
    .OP_WIDTH  (OP_WIDTH),
    .RES_WIDTH (RES_WIDTH)
  ) u_alu (
    .opcode      (opcode),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .result      (alu_res),
    .div_by_zero (alu_dbz)
  );

  assign full_w   = (count_q == (AW+1)'(DEPTH));
  assign empty_w  = (count_q == '0);
  assign mode_chg = (mode != mode_q);

  always_comb begin
    wr_entry.opcode = opcode;
    wr_entry.op_a   = operand_a;
    wr_entry.op_b   = operand_b;
    wr_entry.result = alu_res;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    wr_idx      = write_pointer;
    rd_idx      = read_pointer;

    if (mode_chg) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (!mode) begin
      wr_en = load_en;
      rd_en = read_en;
    end else begin
      wr_idx = wr_ptr_q;
      rd_idx = rd_ptr_q;
      // A read frees a slot in the same edge, so a full FIFO still takes a
      // paired write; an empty FIFO never lets the write fall through.
      wr_en  = load_en && (!full_w || read_en);
      rd_en  = read_en && !empty_w;
      if (load_en && full_w && !read_en) overflow_d  = 1'b1;
      if (read_en && empty_w)            underflow_d = 1'b1;
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
    end

    valid_d = rd_en;
    word_d  = rd_en ? mem_q[rd_idx] : word_q;
    dbz_d   = dbz_q | (wr_en & alu_dbz);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      mode_q      <= mode;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      dbz_q       <= dbz_d;
    end
  end

  // Read data is taken from mem_q before this write lands: read-before-write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_entry;
    end
  end

  assign instruction_word = word_q;
  assign valid_out        = valid_q;
  assign full             = full_w;
  assign empty            = empty_w;
  assign count            = count_q;
  assign overflow         = overflow_q;
  assign underflow        = underflow_q;
  assign div_by_zero      = dbz_q;

endmodule
